// File: rtl/stream_pkg.sv
// Shared types and helpers for the sop/eop/valid packet stream blocks.
package stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_e;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_pkt_checker.sv
// In-band packet protocol checker: decides whether an accepted beat is
// stored and tracks whether a packet is currently open.
module stream_pkt_checker
  import stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
  input  logic       sop,
  input  logic       eop,
  output logic       keep,
  output pkt_state_e next_state,
  output logic       err_orphan,
  output logic       err_nested
);

  pkt_state_e state;

  // Keep/next-state decision for the beat currently offered.
  always_comb begin
    keep       = 1'b1;
    next_state = state;
    unique case (state)
      IDLE: begin
        if (!sop) begin
          keep = 1'b0;
        end else begin
          next_state = eop ? IDLE : IN_PKT;
        end
      end
      IN_PKT: begin
        // A nested sop is stored anyway; its own eop decides where we land.
        next_state = eop ? IDLE : IN_PKT;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Packet-open state and one-cycle error pulses, advanced on accepted beats only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      err_orphan <= 1'b0;
      err_nested <= 1'b0;
    end else begin
      err_orphan <= accept && (state == IDLE) && !sop;
      err_nested <= accept && (state == IN_PKT) && sop;
      if (accept) begin
        state <= next_state;
      end
    end
  end

endmodule

// File: rtl/stream_pkt_fifo.sv
// Parametrised first-word-fall-through packet FIFO with ready backpressure,
// optional store-and-forward presentation and protocol checking.
module stream_pkt_fifo
  import stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned STORE_FWD    = 0,
  parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic [lvl_w(DEPTH)-1:0]   pkt_count,
  output logic                      almost_full,
  output logic                      err_orphan,
  output logic                      err_nested
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = lvl_w(DEPTH);
  localparam int unsigned EW = DATA_WIDTH + 2;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [EW-1:0] head;

  logic       accept;
  logic       keep;
  logic       wr_en;
  logic       pop;
  logic       wr_eop;
  logic       pop_eop;
  logic       has_data;
  pkt_state_e unused_chk_next;

  assign head     = mem[rd_ptr];
  assign in_ready = (level != FULL_LVL);
  assign accept   = in_valid && in_ready;
  assign wr_en    = accept && keep;
  assign pop      = out_valid && out_ready;
  assign wr_eop   = wr_en && in_eop;
  assign pop_eop  = pop && head[0];
  assign has_data = (level != '0);

  assign almost_full = (32'(level) >= AFULL_THRESH);

  stream_pkt_checker u_checker (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .sop        (in_sop),
    .eop        (in_eop),
    .keep       (keep),
    .next_state (unused_chk_next),
    .err_orphan (err_orphan),
    .err_nested (err_nested)
  );

  // Head presentation; store-and-forward waits for a stored eop unless full,
  // so packets longer than the FIFO fall back to cut-through instead of stalling.
  always_comb begin
    if (STORE_FWD != 0) begin
      out_valid = has_data && ((pkt_count != '0) || (level == FULL_LVL));
    end else begin
      out_valid = has_data;
    end
    out_data = out_valid ? head[EW-1:2] : '0;
    out_sop  = out_valid ? head[1]      : 1'b0;
    out_eop  = out_valid ? head[0]      : 1'b0;
  end

  // Payload storage; entries need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {in_data, in_sop, in_eop};
    end
  end

  // Pointers, occupancy and stored-packet count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      unique case ({wr_eop, pop_eop})
        2'b10:   pkt_count <= pkt_count + LW'(1);
        2'b01:   pkt_count <= pkt_count - LW'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule
